mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 113 +++++++++++
 tb/tb_mdu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Fixed latency: 5 cycles for mult/multu, 10 cycles for div/divu.
module mdu (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IR_E,
    input  logic        En,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        StartBusy,
    output logic [31:0] MDOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic [31:0] opa, opb;
    logic [31:0] hi, lo;

    logic [5:0]  funct;
    logic        is_r, is_md, start, finish;
    logic        mfhi, mflo, mthi, mtlo;

    assign funct  = IR_E[5:0];
    assign is_r   = En && (IR_E[31:26] == 6'b000000);
    assign is_md  = is_r && (funct[5:2] == 4'b0110);
    assign mfhi   = is_r && (funct == 6'b010000);
    assign mthi   = is_r && (funct == 6'b010001) && !Busy;
    assign mflo   = is_r && (funct == 6'b010010);
    assign mtlo   = is_r && (funct == 6'b010011) && !Busy;
    assign start  = is_md && !Busy;
    assign finish = (state == RUN) && (cnt == 4'd1);

    assign Busy      = (state == RUN);
    assign StartBusy = start || Busy;
    assign MDOut     = mfhi ? hi : (mflo ? lo : '0);
    assign HI        = hi;
    assign LO        = lo;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start)  state_next = RUN;
            RUN:  if (finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result datapath, evaluated from the operands latched at Start.
    logic [63:0] prod_s, prod_u;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, dsor_u;
    logic [31:0] uq, ur, sq, sr;

    always_comb begin
        prod_s = {{32{opa[31]}}, opa} * {{32{opb[31]}}, opb};
        prod_u = {32'd0, opa} * {32'd0, opb};
        neg_a  = opa[31];
        neg_b  = opb[31];
        mag_a  = neg_a ? (32'd0 - opa) : opa;
        mag_b  = neg_b ? (32'd0 - opb) : opb;
        if (mag_b == '0) mag_b = 32'd1;
        dsor_u = (opb == '0) ? 32'd1 : opb;
        // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        uq     = mag_a / mag_b;
        ur     = mag_a % mag_b;
        sq     = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        sr     = neg_a ? (32'd0 - ur) : ur;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hi  <= '0;
            lo  <= '0;
            cnt <= '0;
            opa <= '0;
            opb <= '0;
            op  <= '0;
        end else begin
            if (start) begin
                opa <= A;
                opb <= B;
                op  <= funct[1:0];
                cnt <= funct[1] ? 4'd10 : 4'd5;
            end else if (state == RUN) begin
                cnt <= cnt - 4'd1;
            end

            if (finish) begin
                case (op)
                    2'b00: begin hi <= prod_s[63:32]; lo <= prod_s[31:0]; end
                    2'b01: begin hi <= prod_u[63:32]; lo <= prod_u[31:0]; end
                    2'b10: if (opb != '0) begin hi <= sr; lo <= sq; end
                    default: if (opb != '0) begin hi <= opb == '0 ? hi : opa % dsor_u; lo <= opa / dsor_u; end
                endcase
            end else begin
                if (mthi) hi <= A;
                if (mtlo) lo <= A;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO pushed at issue, popped at completion.
module tb_mdu;

    logic        Clk, Reset, En;
    logic [31:0] IR_E, A, B;
    logic        Busy, StartBusy;
    logic [31:0] MDOut, HI, LO;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [63:0] sb_q[$];
    logic [63:0] cur = '0;

    mdu dut (
        .Clk(Clk), .Reset(Reset), .IR_E(IR_E), .En(En), .A(A), .B(B),
        .Busy(Busy), .StartBusy(StartBusy), .MDOut(MDOut), .HI(HI), .LO(LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr(input logic [5:0] f);
        return {6'b000000, 20'd0, f};
    endfunction

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] prev);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = $signed(a);
        sb = $signed(b);
        res = prev;
        case (f)
            F_MULT:  res = sa * sb;
            F_MULTU: res = {32'd0, a} * {32'd0, b};
            F_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            F_DIVU:  if (b != 0) res = {a % b, a / b};
            default: res = prev;
        endcase
        return res;
    endfunction

    task automatic read_hilo(input string tag, input logic [63:0] exp);
        @(negedge Clk);
        IR_E = instr(F_MFHI); En = 1'b1;
        #1 chk({tag, "_mfhi"}, {32'd0, MDOut}, {32'd0, exp[63:32]});
        IR_E = instr(F_MFLO);
        #1 chk({tag, "_mflo"}, {32'd0, MDOut}, {32'd0, exp[31:0]});
        En = 1'b0; IR_E = '0;
    endtask

    task automatic mt(input logic [5:0] f, input logic [31:0] a);
        @(negedge Clk);
        IR_E = instr(f); En = 1'b1; A = a;
        @(negedge Clk);
        En = 1'b0; IR_E = '0;
        if (f == F_MTHI) cur[63:32] = a; else cur[31:0] = a;
        chk("mt_hilo", {HI, LO}, cur);
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        int unsigned nbusy;
        logic [63:0] e;
        cur = model(f, a, b, cur);
        sb_q.push_back(cur);
        @(negedge Clk);
        IR_E = instr(f); En = 1'b1; A = a; B = b;
        #1 chk({tag, "_startbusy"}, {63'd0, StartBusy}, 64'd1);
        @(negedge Clk);
        En = 1'b0; IR_E = '0;
        nbusy = 0;
        for (int i = 0; i < 40 && Busy; i++) begin
            nbusy++;
            A = $urandom; B = $urandom;
            @(negedge Clk);
        end
        chk({tag, "_busycycles"}, 64'(nbusy), f[1] ? 64'd10 : 64'd5);
        e = sb_q.pop_front();
        chk({tag, "_hilo"}, {HI, LO}, e);
    endtask

    initial begin
        logic [31:0] ra, rb;
        Reset = 1'b1; En = 1'b0; IR_E = '0; A = '0; B = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_startbusy", {63'd0, StartBusy}, 64'd0);
        chk("rst_hilo", {HI, LO}, 64'd0);
        read_hilo("rst", 64'd0);

        run_op("mult_neg", F_MULT, 32'hFFFFFFFE, 32'd3);
        chk("mult_neg_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
        read_hilo("mult_neg", 64'hFFFFFFFF_FFFFFFFA);
        run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_max_const", {HI, LO}, 64'hFFFFFFFE_00000001);
        run_op("div_neg", F_DIV, 32'hFFFFFFF9, 32'd2);
        chk("div_neg_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        read_hilo("div_neg", 64'hFFFFFFFF_FFFFFFFD);

        mt(F_MTHI, 32'h1234);
        mt(F_MTLO, 32'h5678);
        run_op("divu_zero", F_DIVU, 32'd7, 32'd0);
        chk("divu_zero_const", {HI, LO}, 64'h00001234_00005678);
        run_op("div_zero", F_DIV, 32'd9, 32'd0);

        run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_const", {HI, LO}, 64'h00000000_80000000);
        run_op("div_negdsor", F_DIV, 32'd7, 32'hFFFFFFFE);
        run_op("divu_big", F_DIVU, 32'hFFFFFFF0, 32'd7);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 3 == 2) rb = rb >> 20;
            run_op("rand", 6'b011000 | 6'(i % 4), ra, rb);
        end

        // Second mult and mtlo during Busy must be ignored.
        cur = model(F_MULT, 32'd1000, 32'hFFFFFFFD, cur);
        sb_q.push_back(cur);
        @(negedge Clk);
        IR_E = instr(F_MULT); En = 1'b1; A = 32'd1000; B = 32'hFFFFFFFD;
        @(negedge Clk);
        A = 32'd77; B = 32'd99;
        #1 chk("busy_startbusy", {63'd0, StartBusy}, 64'd1);
        @(negedge Clk);
        IR_E = instr(F_MTLO); A = 32'hDEADBEEF;
        @(negedge Clk);
        IR_E = instr(F_MTHI);
        @(negedge Clk);
        En = 1'b0; IR_E = '0;
        for (int i = 0; i < 40 && Busy; i++) @(negedge Clk);
        chk("ignore_busy", {63'd0, Busy}, 64'd0);
        chk("ignore_hilo", {HI, LO}, sb_q.pop_front());

        // Abort a divide on its 4th busy cycle.
        @(negedge Clk);
        IR_E = instr(F_DIV); En = 1'b1; A = 32'd100; B = 32'd7;
        @(negedge Clk);
        En = 1'b0; IR_E = '0;
        repeat (3) @(negedge Clk);
        chk("abort_pre_busy", {63'd0, Busy}, 64'd1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        cur = '0;
        chk("abort_busy", {63'd0, Busy}, 64'd0);
        chk("abort_hilo", {HI, LO}, 64'd0);
        read_hilo("abort", 64'd0);
        repeat (12) @(negedge Clk);
        chk("abort_stays", {HI, LO}, 64'd0);

        // Reset wins over a simultaneous Start.
        @(negedge Clk);
        IR_E = instr(F_MULTU); En = 1'b1; A = 32'd5; B = 32'd6; Reset = 1'b1;
        @(negedge Clk);
        En = 1'b0; IR_E = '0; Reset = 1'b0;
        chk("rst_vs_start_busy", {63'd0, Busy}, 64'd0);
        repeat (6) @(negedge Clk);
        chk("rst_vs_start_hilo", {HI, LO}, 64'd0);

        run_op("post_rst", F_MULTU, 32'd5, 32'd6);
        read_hilo("post_rst", 64'd30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
